// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, PSLVERR bit positions and
// default bus widths. Used by both the APB initiator and the APB slave.
package apb_pkg;

  localparam int unsigned APB_DATA_WD = 32;
  localparam int unsigned APB_ADDR_WD = 16;

  // PSLVERR is {parity_err, addr_err}
  localparam int unsigned PSLVERR_ADDR_BIT   = 0;
  localparam int unsigned PSLVERR_PARITY_BIT = 1;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'b00,
    APB_SETUP  = 2'b01,
    APB_ACCESS = 2'b10
  } apb_state_e;

endpackage

// File: rtl/apb_master_if.sv
// Application command/response port plus APB bus of the APB initiator.
// The master modport is the initiator's view; slave is the opposite side.
interface apb_master_if
  import apb_pkg::*;
#(
  parameter int unsigned DATA_WD = APB_DATA_WD,
  parameter int unsigned ADDR_WD = APB_ADDR_WD
);

  logic               CMD_VALID;
  logic               CMD_READY;
  logic               CMD_WRITE;
  logic [ADDR_WD-1:0] CMD_ADDR;
  logic [DATA_WD-1:0] CMD_WDATA;
  logic [3:0]         CMD_STRB;

  logic               RSP_VALID;
  logic [DATA_WD-1:0] RSP_RDATA;
  logic [1:0]         RSP_ERR;
  logic               RSP_TMO;

  logic               PSEL;
  logic               PENABLE;
  logic               PWRITE;
  logic [ADDR_WD-1:0] PADDR;
  logic [DATA_WD-1:0] PWDATA;
  logic [3:0]         PSTRB;
  logic               PREADY;
  logic [DATA_WD-1:0] PRDATA;
  logic [1:0]         PSLVERR;

  modport master (
    input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, CMD_STRB,
    output CMD_READY,
    output RSP_VALID, RSP_RDATA, RSP_ERR, RSP_TMO,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, CMD_STRB,
    input  CMD_READY,
    input  RSP_VALID, RSP_RDATA, RSP_ERR, RSP_TMO,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PREADY, PRDATA, PSLVERR
  );

endinterface

// File: rtl/apb_master.sv
// APB initiator: turns single-beat application commands into APB
// SETUP/ACCESS transfers, waits on PREADY with an optional wait-state
// timeout, and returns a one-cycle registered response pulse.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned DATA_WD = APB_DATA_WD,
  parameter int unsigned ADDR_WD = APB_ADDR_WD,
  parameter int unsigned TMO_WD  = 8
)(
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic [TMO_WD-1:0] TMO_LIMIT,
  apb_master_if.master      bus
);

  apb_state_e         state, state_nxt;
  logic               cmd_hs, done, tmo_hit;
  logic [TMO_WD-1:0]  wait_cnt, cnt_inc;

  logic               psel_q, penable_q, pwrite_q;
  logic [ADDR_WD-1:0] paddr_q;
  logic [DATA_WD-1:0] pwdata_q;
  logic [3:0]         pstrb_q;

  logic               rsp_valid_q, rsp_tmo_q;
  logic [DATA_WD-1:0] rsp_rdata_q;
  logic [1:0]         rsp_err_q;

  assign bus.CMD_READY = (state == APB_IDLE);
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.PSTRB     = pstrb_q;
  assign bus.RSP_VALID = rsp_valid_q;
  assign bus.RSP_RDATA = rsp_rdata_q;
  assign bus.RSP_ERR   = rsp_err_q;
  assign bus.RSP_TMO   = rsp_tmo_q;

  // Next-state and transfer-event decode
  always_comb begin
    state_nxt = state;
    cmd_hs    = 1'b0;
    done      = 1'b0;
    tmo_hit   = 1'b0;
    cnt_inc   = wait_cnt + TMO_WD'(1);
    case (state)
      APB_IDLE: begin
        if (bus.CMD_VALID) begin
          cmd_hs    = 1'b1;
          state_nxt = APB_SETUP;
        end
      end
      APB_SETUP: state_nxt = APB_ACCESS;
      APB_ACCESS: begin
        // PREADY takes priority over a timeout hitting on the same edge
        if (bus.PREADY) begin
          done      = 1'b1;
          state_nxt = APB_IDLE;
        end else if ((TMO_LIMIT != '0) && (cnt_inc == TMO_LIMIT)) begin
          tmo_hit   = 1'b1;
          state_nxt = APB_IDLE;
        end
      end
      default: state_nxt = APB_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= APB_IDLE;
    else        state <= state_nxt;
  end

  // APB output registers; PSEL/PENABLE follow the next state so they are glitch-free
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
    end else begin
      psel_q    <= (state_nxt != APB_IDLE);
      penable_q <= (state_nxt == APB_ACCESS);
      if (cmd_hs) begin
        pwrite_q <= bus.CMD_WRITE;
        paddr_q  <= bus.CMD_ADDR;
        pwdata_q <= bus.CMD_WRITE ? bus.CMD_WDATA : '0;
        pstrb_q  <= bus.CMD_WRITE ? bus.CMD_STRB  : '0;
      end
    end
  end

  // Wait-state counter: cleared entering SETUP, counts ACCESS cycles without PREADY
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)                                   wait_cnt <= '0;
    else if (cmd_hs)                              wait_cnt <= '0;
    else if (state == APB_ACCESS && !bus.PREADY)  wait_cnt <= cnt_inc;
  end

  // Response pulse; fields hold until the next completion or timeout
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= '0;
      rsp_tmo_q   <= 1'b0;
    end else begin
      rsp_valid_q <= done | tmo_hit;
      if (done) begin
        rsp_rdata_q <= pwrite_q ? '0 : bus.PRDATA;
        rsp_err_q   <= {bus.PSLVERR[PSLVERR_PARITY_BIT], bus.PSLVERR[PSLVERR_ADDR_BIT]};
        rsp_tmo_q   <= 1'b0;
      end else if (tmo_hit) begin
        rsp_rdata_q <= '0;
        rsp_err_q   <= 2'b00;
        rsp_tmo_q   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: single transfers with wait states, slave
// error, timeout and its PREADY-priority boundary, back-to-back commands,
// and asynchronous reset in the middle of ACCESS.
module tb_apb_master;

  logic       PCLK = 1'b0;
  logic       PRESET = 1'b1;
  logic [7:0] TMO_LIMIT;

  logic        prd_echo;
  logic [31:0] prd_reg;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  apb_master_if #(.DATA_WD(32), .ADDR_WD(16)) bus ();

  apb_master #(.DATA_WD(32), .ADDR_WD(16), .TMO_WD(8)) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .TMO_LIMIT (TMO_LIMIT),
    .bus       (bus)
  );

  always #5 PCLK = ~PCLK;

  // Slave read data: fixed value, or an address echo for back-to-back reads
  assign bus.PRDATA = prd_echo ? {16'hA5A5, bus.PADDR} : prd_reg;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge PCLK);
  endtask

  // One command from an idle negedge through its response; ends on an idle negedge
  task automatic run_xfer(
    input string       tag,
    input logic        wr,
    input logic [15:0] addr,
    input logic [31:0] wd,
    input logic [3:0]  strb,
    input int unsigned nacc,
    input int unsigned rdy_at,
    input logic [31:0] prd,
    input logic [1:0]  serr,
    input logic [31:0] exp_pwdata,
    input logic [3:0]  exp_pstrb,
    input logic [31:0] exp_rdata,
    input logic [1:0]  exp_err,
    input logic        exp_tmo
  );
    chk({tag, " cmd_ready"}, bus.CMD_READY, 1);
    bus.CMD_VALID = 1'b1;
    bus.CMD_WRITE = wr;
    bus.CMD_ADDR  = addr;
    bus.CMD_WDATA = wd;
    bus.CMD_STRB  = strb;
    bus.PREADY    = 1'b0;
    bus.PSLVERR   = serr;
    prd_reg       = prd;
    cyc();
    // scramble command inputs: they must be ignored outside the IDLE handshake
    bus.CMD_VALID = 1'b0;
    bus.CMD_WRITE = ~wr;
    bus.CMD_ADDR  = ~addr;
    bus.CMD_WDATA = ~wd;
    bus.CMD_STRB  = ~strb;
    chk({tag, " setup psel"},    bus.PSEL, 1);
    chk({tag, " setup penable"}, bus.PENABLE, 0);
    chk({tag, " setup paddr"},   bus.PADDR, addr);
    chk({tag, " setup pwrite"},  bus.PWRITE, wr);
    chk({tag, " setup pwdata"},  bus.PWDATA, exp_pwdata);
    chk({tag, " setup pstrb"},   bus.PSTRB, exp_pstrb);
    chk({tag, " setup ready"},   bus.CMD_READY, 0);
    cyc();
    for (int k = 0; k < int'(nacc); k++) begin
      bus.PREADY = (k == int'(rdy_at));
      chk({tag, " acc psel"},    bus.PSEL, 1);
      chk({tag, " acc penable"}, bus.PENABLE, 1);
      chk({tag, " acc paddr"},   bus.PADDR, addr);
      chk({tag, " acc pstrb"},   bus.PSTRB, exp_pstrb);
      chk({tag, " acc rsp_vld"}, bus.RSP_VALID, 0);
      cyc();
    end
    bus.PREADY = 1'b0;
    chk({tag, " rsp psel"},    bus.PSEL, 0);
    chk({tag, " rsp penable"}, bus.PENABLE, 0);
    chk({tag, " rsp valid"},   bus.RSP_VALID, 1);
    chk({tag, " rsp rdata"},   bus.RSP_RDATA, exp_rdata);
    chk({tag, " rsp err"},     bus.RSP_ERR, exp_err);
    chk({tag, " rsp tmo"},     bus.RSP_TMO, exp_tmo);
    chk({tag, " rsp ready"},   bus.CMD_READY, 1);
    chk({tag, " idle paddr"},  bus.PADDR, addr);
    cyc();
    chk({tag, " post valid"},  bus.RSP_VALID, 0);
    chk({tag, " post rdata"},  bus.RSP_RDATA, exp_rdata);
    chk({tag, " post tmo"},    bus.RSP_TMO, exp_tmo);
  endtask

  logic [15:0] b2b_addr [3];
  logic [31:0] b2b_data [3];

  initial begin
    bus.CMD_VALID = 1'b0;
    bus.CMD_WRITE = 1'b0;
    bus.CMD_ADDR  = '0;
    bus.CMD_WDATA = '0;
    bus.CMD_STRB  = '0;
    bus.PREADY    = 1'b0;
    bus.PSLVERR   = 2'b00;
    prd_echo      = 1'b0;
    prd_reg       = '0;
    TMO_LIMIT     = 8'd0;

    // reset state
    cyc();
    chk("rst psel",      bus.PSEL, 0);
    chk("rst penable",   bus.PENABLE, 0);
    chk("rst pwrite",    bus.PWRITE, 0);
    chk("rst paddr",     bus.PADDR, 0);
    chk("rst pwdata",    bus.PWDATA, 0);
    chk("rst pstrb",     bus.PSTRB, 0);
    chk("rst rsp_valid", bus.RSP_VALID, 0);
    chk("rst rsp_rdata", bus.RSP_RDATA, 0);
    chk("rst rsp_err",   bus.RSP_ERR, 0);
    chk("rst rsp_tmo",   bus.RSP_TMO, 0);
    PRESET = 1'b0;
    cyc();

    //        tag        wr    addr      wdata          strb     nacc rdy prdata         serr   exp_pwdata     exp_pstrb exp_rdata      err    tmo
    run_xfer("wr0",      1'b1, 16'h0040, 32'hDEADBEEF, 4'b1111, 1,   0,  32'h0BADF00D, 2'b00, 32'hDEADBEEF, 4'b1111, 32'h00000000, 2'b00, 1'b0);
    run_xfer("rd3",      1'b0, 16'h0010, 32'hFFFFFFFF, 4'b1111, 4,   3,  32'h12345678, 2'b00, 32'h00000000, 4'b0000, 32'h12345678, 2'b00, 1'b0);
    run_xfer("wr_serr",  1'b1, 16'h0020, 32'hCAFE0001, 4'b0101, 1,   0,  32'h00000000, 2'b10, 32'hCAFE0001, 4'b0101, 32'h00000000, 2'b10, 1'b0);
    run_xfer("wr_strb0", 1'b1, 16'h0030, 32'h00000077, 4'b0000, 2,   1,  32'h00000000, 2'b00, 32'h00000077, 4'b0000, 32'h00000000, 2'b00, 1'b0);

    TMO_LIMIT = 8'd4;
    run_xfer("tmo4",     1'b0, 16'h0050, 32'h00000000, 4'b0000, 4,   99, 32'h11112222, 2'b11, 32'h00000000, 4'b0000, 32'h00000000, 2'b00, 1'b1);
    run_xfer("tmo4_rdy", 1'b0, 16'h0054, 32'h00000000, 4'b0000, 4,   3,  32'h87654321, 2'b01, 32'h00000000, 4'b0000, 32'h87654321, 2'b01, 1'b0);
    TMO_LIMIT = 8'd1;
    run_xfer("tmo1",     1'b1, 16'h0058, 32'h0000ABCD, 4'b1100, 1,   99, 32'h00000000, 2'b01, 32'h0000ABCD, 4'b1100, 32'h00000000, 2'b00, 1'b1);
    TMO_LIMIT = 8'd0;

    // back-to-back: three reads with CMD_VALID held, zero wait states
    b2b_addr[0] = 16'h0100; b2b_data[0] = 32'hA5A50100;
    b2b_addr[1] = 16'h0104; b2b_data[1] = 32'hA5A50104;
    b2b_addr[2] = 16'h0108; b2b_data[2] = 32'hA5A50108;
    prd_echo      = 1'b1;
    bus.PREADY    = 1'b1;
    bus.PSLVERR   = 2'b00;
    bus.CMD_WRITE = 1'b0;
    bus.CMD_ADDR  = b2b_addr[0];
    bus.CMD_VALID = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      cyc();
      if (c == 1) bus.CMD_ADDR = b2b_addr[1];
      if (c == 4) bus.CMD_ADDR = b2b_addr[2];
      if (c == 7) bus.CMD_VALID = 1'b0;
      if (c % 3 == 1) chk("b2b paddr", bus.PADDR, b2b_addr[(c - 1) / 3]);
      if (c % 3 == 0) begin
        chk("b2b rsp_valid", bus.RSP_VALID, 1);
        chk("b2b rsp_rdata", bus.RSP_RDATA, b2b_data[c / 3 - 1]);
      end else begin
        chk("b2b rsp_idle", bus.RSP_VALID, 0);
      end
    end
    cyc();
    chk("b2b end psel", bus.PSEL, 0);
    chk("b2b end rsp",  bus.RSP_VALID, 0);
    prd_echo   = 1'b0;
    bus.PREADY = 1'b0;

    // asynchronous reset while in ACCESS
    bus.CMD_VALID = 1'b1;
    bus.CMD_WRITE = 1'b1;
    bus.CMD_ADDR  = 16'h0ABC;
    bus.CMD_WDATA = 32'h5555AAAA;
    bus.CMD_STRB  = 4'b0011;
    cyc();
    bus.CMD_VALID = 1'b0;
    cyc();
    chk("mid penable", bus.PENABLE, 1);
    #2 PRESET = 1'b1;
    #1;
    chk("arst psel",      bus.PSEL, 0);
    chk("arst penable",   bus.PENABLE, 0);
    chk("arst pwrite",    bus.PWRITE, 0);
    chk("arst paddr",     bus.PADDR, 0);
    chk("arst pwdata",    bus.PWDATA, 0);
    chk("arst pstrb",     bus.PSTRB, 0);
    chk("arst rsp_valid", bus.RSP_VALID, 0);
    chk("arst rsp_rdata", bus.RSP_RDATA, 0);
    cyc();
    bus.PREADY = 1'b1;
    cyc();
    chk("arst hold rsp",  bus.RSP_VALID, 0);
    PRESET     = 1'b0;
    bus.PREADY = 1'b0;
    cyc();
    chk("arst rel rsp",   bus.RSP_VALID, 0);
    chk("arst rel psel",  bus.PSEL, 0);
    chk("arst rel ready", bus.CMD_READY, 1);
    run_xfer("after_rst", 1'b0, 16'h0060, 32'h00000000, 4'b0000, 2, 1, 32'h0F0F0F0F, 2'b00, 32'h00000000, 4'b0000, 32'h0F0F0F0F, 2'b00, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
